button_conditioner: RTL and testbench

Front-end input stage between the raw Basys push-buttons (btnU/btnD/btnL/btnR/btnC) and the combo-lock logic: the up/down value selector, the pin shift register, the entry counter and the lock state machine. Per button, it synchronises to clk, debounces, and emits single-cycle press/release pulses. It has optional auto-repeat, so a held left/right button steps the value selector. All downstream blocks then run on clk with clean one-cycle strobes instead of raw button edges.

---
 rtl/btn_pkg.sv | 26 ++
 rtl/btn_channel.sv | 129 ++++++++++++
 rtl/button_conditioner.sv | 36 +++
 tb/tb_button_conditioner.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the push-button front end: repeat FSM encoding,
// default 100 MHz board timing, and the counter-width helper.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    DELAY  = 2'd2,
    REPEAT = 2'd3
  } rpt_state_t;

  localparam int DEF_NUM_BTN         = 5;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;  // 10 ms
  localparam int DEF_REPEAT_DELAY    = 50_000_000; // 500 ms
  localparam int DEF_REPEAT_PERIOD   = 10_000_000; // 100 ms

  // Width of a counter that counts 0 .. n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop synchroniser, stability debouncer and auto-repeat FSM.
// Level/press/release change DEBOUNCE_CYCLES+2 edges after a raw change; strobes are fire-and-forget.
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic repeat_en,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int RW = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));

  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST   = RW'(REPEAT_PERIOD - 1);

  logic          sync1;
  logic          sync2;
  logic [DW-1:0] db_cnt;
  logic [RW-1:0] rpt_cnt;
  rpt_state_t    state;

  logic toggle;
  logic rise;
  logic fall;

  // The FSM reacts on the same edge the debounced level flips, so the
  // strobes line up exactly with the first cycle of the new level.
  assign toggle = (sync2 != level) && (db_cnt == DB_LAST);
  assign rise   = toggle && !level;
  assign fall   = toggle && level;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      db_cnt <= '0;
      level  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt <= '0;
        level  <= ~level;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rpt_cnt       <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        IDLE: begin
          rpt_cnt <= '0;
          if (rise) begin
            press_pulse <= 1'b1;
            state       <= repeat_en ? DELAY : HELD;
          end
        end

        HELD: begin
          rpt_cnt <= '0;
          if (fall) begin
            release_pulse <= 1'b1;
            state         <= IDLE;
          end
        end

        DELAY: begin
          if (fall) begin
            release_pulse <= 1'b1;
            rpt_cnt       <= '0;
            state         <= IDLE;
          end else if (!repeat_en) begin
            rpt_cnt <= '0;
            state   <= HELD;
          end else if (rpt_cnt == DELAY_LAST) begin
            press_pulse <= 1'b1;
            rpt_cnt     <= '0;
            state       <= REPEAT;
          end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
          end
        end

        REPEAT: begin
          if (fall) begin
            release_pulse <= 1'b1;
            rpt_cnt       <= '0;
            state         <= IDLE;
          end else if (!repeat_en) begin
            rpt_cnt <= '0;
            state   <= HELD;
          end else if (rpt_cnt == PER_LAST) begin
            press_pulse <= 1'b1;
            rpt_cnt     <= '0;
          end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
          end
        end

        default: begin
          rpt_cnt <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Raw board buttons to clean clk-domain level, press (with auto-repeat) and release strobes.
// Latency DEBOUNCE_CYCLES+2 edges per channel; no backpressure, consumers must take strobes when they fire.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int NUM_BTN         = DEF_NUM_BTN,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic [NUM_BTN-1:0] repeat_en,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .raw          (btn_raw[i]),
      .repeat_en    (repeat_en[i]),
      .level        (btn_level[i]),
      .press_pulse  (btn_press[i]),
      .release_pulse(btn_release[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench: stimulus pushes expected press/release strobes by cycle,
// a negedge monitor compares every channel's strobes every cycle.
module tb_button_conditioner;

  localparam int NB = 5;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 5;
  localparam int LAT = DB + 2;

  typedef struct {
    int cyc;
    int ch;
    bit is_rel;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] btn_raw = '0;
  logic [NB-1:0] repeat_en = '0;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;

  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  bit  mon_on = 1'b0;
  ev_t sb[$];
  logic m_got;
  logic m_want;

  button_conditioner #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .repeat_en  (repeat_en),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input int c, input int ch, input bit r);
    sb.push_back('{cyc: c, ch: ch, is_rel: r});
  endtask

  // Repeat presses for a hold whose initial press is at t and level falls at tf.
  task automatic expect_repeats(input int ch, input int t, input int tf);
    for (int c = t + RD; c < tf; c += RP) expect_ev(c, ch, 1'b0);
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      for (int i = 0; i < NB; i++) begin
        for (int k = 0; k < 2; k++) begin
          m_want = 1'b0;
          m_got  = (k == 1) ? btn_release[i] : btn_press[i];
          for (int j = 0; j < sb.size(); j++) begin
            if (sb[j].cyc == cyc && sb[j].ch == i && sb[j].is_rel == (k == 1)) begin
              m_want = 1'b1;
              sb.delete(j);
              break;
            end
          end
          chk($sformatf("%s[%0d]", (k == 1) ? "release" : "press", i), {31'd0, m_got}, {31'd0, m_want});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, t, tf, cr;

    // Reset state
    step(3);
    chk("rst_level", {27'd0, btn_level}, 32'd0);
    chk("rst_press", {27'd0, btn_press}, 32'd0);
    chk("rst_release", {27'd0, btn_release}, 32'd0);
    rst = 1'b0;
    mon_on = 1'b1;
    step(4);

    // 1: clean press, no repeat
    c = cyc;
    btn_raw[0] = 1'b1;
    expect_ev(c + LAT, 0, 1'b0);
    step(LAT - 1);
    chk("t1_level_before", {31'd0, btn_level[0]}, 32'd0);
    step(1);
    chk("t1_level_after", {31'd0, btn_level[0]}, 32'd1);
    step(20 - LAT);
    c = cyc;
    btn_raw[0] = 1'b0;
    expect_ev(c + LAT, 0, 1'b1);
    step(LAT);
    chk("t1_level_released", {31'd0, btn_level[0]}, 32'd0);
    step(6);

    // 2: bounce rejection
    for (int k = 0; k < 8; k++) begin
      btn_raw[2] = ~btn_raw[2];
      step(2);
    end
    c = cyc;
    btn_raw[2] = 1'b1;
    expect_ev(c + LAT, 2, 1'b0);
    step(LAT + 6);
    chk("t2_level", {31'd0, btn_level[2]}, 32'd1);
    c = cyc;
    btn_raw[2] = 1'b0;
    expect_ev(c + LAT, 2, 1'b1);
    step(LAT + 6);

    // 3: auto-repeat; level falls exactly on a would-be repeat cycle
    repeat_en[3] = 1'b1;
    c = cyc;
    btn_raw[3] = 1'b1;
    t = c + LAT;
    tf = c + 40 + LAT;
    expect_ev(t, 3, 1'b0);
    expect_repeats(3, t, tf);
    expect_ev(tf, 3, 1'b1);
    step(40);
    btn_raw[3] = 1'b0;
    step(LAT + 8);

    // 4: repeat disabled mid-hold
    c = cyc;
    btn_raw[3] = 1'b1;
    t = c + LAT;
    expect_ev(t, 3, 1'b0);
    expect_ev(t + RD, 3, 1'b0);
    step(LAT + 12);
    repeat_en[3] = 1'b0;
    step(30 - (LAT + 12));
    c = cyc;
    btn_raw[3] = 1'b0;
    expect_ev(c + LAT, 3, 1'b1);
    step(LAT + 6);

    // 5: simultaneous, independent channels
    c = cyc;
    btn_raw[1] = 1'b1;
    btn_raw[4] = 1'b1;
    expect_ev(c + LAT, 1, 1'b0);
    expect_ev(c + LAT, 4, 1'b0);
    step(LAT);
    chk("t5_levels", {27'd0, btn_level}, 32'h12);
    step(2);
    btn_raw[1] = 1'b0;
    expect_ev(c + 8 + LAT, 1, 1'b1);
    step(7);
    btn_raw[4] = 1'b0;
    expect_ev(c + 15 + LAT, 4, 1'b1);
    step(LAT + 6);
    chk("t5_levels_low", {27'd0, btn_level}, 32'd0);

    // 6: reset mid-repeat with the button still held
    repeat_en[3] = 1'b1;
    c = cyc;
    btn_raw[3] = 1'b1;
    t = c + LAT;
    expect_ev(t, 3, 1'b0);
    expect_ev(t + RD, 3, 1'b0);
    step(LAT + 13);
    rst = 1'b1;
    #1;
    chk("t6_rst_level", {27'd0, btn_level}, 32'd0);
    chk("t6_rst_press", {27'd0, btn_press}, 32'd0);
    chk("t6_rst_release", {27'd0, btn_release}, 32'd0);
    step(3);
    cr = cyc;
    rst = 1'b0;
    tf = cr + 25 + LAT;
    expect_ev(cr + LAT, 3, 1'b0);
    expect_repeats(3, cr + LAT, tf);
    expect_ev(tf, 3, 1'b1);
    step(25);
    btn_raw[3] = 1'b0;
    step(LAT + 10);

    chk("leftover", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
